// File: rtl/vector_add_collector.sv
// Collector for the 16-lane fp32 vector adder result stream: credit-based issue grant, result FIFO, valid/ready output.
// Optional performance counters are enabled by defining VADD_COLLECT_PERF_EN.
module vector_add_collector #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_req,
  output logic              issue_grant,
  input  logic              vector_output_valid,
  input  logic [DATA_W-1:0] vector,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  occupancy,
  output logic              err_unexpected
`ifdef VADD_COLLECT_PERF_EN
  ,
  output logic [31:0]       perf_results,
  output logic [31:0]       perf_stall_issue,
  output logic [31:0]       perf_stall_out
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  inflight, count;
  logic [CNT_W:0]    credit_used;
  logic              issue_fire, credited, push, pop;

  assign m_valid     = (count != '0);
  assign pop         = m_valid & m_ready;
  // A pop accepted this cycle returns its credit immediately.
  assign credit_used = {1'b0, inflight} + {1'b0, count} - {{CNT_W{1'b0}}, pop};
  assign issue_grant = rst_n & (credit_used < DEPTH_W);
  assign issue_fire  = issue_req & issue_grant;
  assign credited    = vector_output_valid & (inflight != '0);
  assign push        = vector_output_valid & ({1'b0, count} < DEPTH_W);
  assign occupancy   = inflight + count;
  assign m_data      = m_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight       <= '0;
      count          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      err_unexpected <= 1'b0;
    end else begin
      case ({issue_fire, credited})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (vector_output_valid && (inflight == '0)) err_unexpected <= 1'b1;
    end
  end

  // Storage carries no reset; m_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= vector;
  end

`ifdef VADD_COLLECT_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_results     <= '0;
      perf_stall_issue <= '0;
      perf_stall_out   <= '0;
    end else begin
      if (push)                      perf_results     <= sat_inc(perf_results);
      if (issue_req && !issue_grant) perf_stall_issue <= sat_inc(perf_stall_issue);
      if (m_valid && !m_ready)       perf_stall_out   <= sat_inc(perf_stall_out);
    end
  end
`endif

endmodule

// File: tb/tb_vector_add_collector.sv
// Self-checking bench for vector_add_collector: table-driven single passes, scoreboard on the output stream,
// and hand-written credit, wrap, simultaneous-event and unexpected-result sequences.
module tb_vector_add_collector;

  localparam int DATA_W = 512;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;
  localparam int LAT    = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue_req;
  logic              issue_grant;
  logic              vector_output_valid;
  logic [DATA_W-1:0] vector;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic [CNT_W-1:0]  occupancy;
  logic              err_unexpected;
`ifdef VADD_COLLECT_PERF_EN
  logic [31:0]       perf_results, perf_stall_issue, perf_stall_out;
`endif

  always #5 clk = ~clk;

  vector_add_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .issue_req           (issue_req),
    .issue_grant         (issue_grant),
    .vector_output_valid (vector_output_valid),
    .vector              (vector),
    .m_valid             (m_valid),
    .m_data              (m_data),
    .m_ready             (m_ready),
    .occupancy           (occupancy),
    .err_unexpected      (err_unexpected)
`ifdef VADD_COLLECT_PERF_EN
    ,
    .perf_results        (perf_results),
    .perf_stall_issue    (perf_stall_issue),
    .perf_stall_out      (perf_stall_out)
`endif
  );

  typedef struct {
    logic [31:0]       tag;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  vec_t              tbl [4];
  int                n_cmp = 0;
  int                n_bad = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic              pipe_v [LAT];
  logic [31:0]       pipe_t [LAT];
  logic [31:0]       tag;
  logic              inj;
  logic [DATA_W-1:0] inj_d;
  int                fires, results, pops;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: scoreboard check at negedge, then adder model and result drive just after posedge.
  task automatic step();
    logic              fire_s;
    logic [DATA_W-1:0] e;
    @(negedge clk);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: got %0h expected nothing", m_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", m_data, e);
      end
      pops++;
    end
    fire_s = issue_req & issue_grant;
    @(posedge clk);
    #1;
    vector_output_valid = pipe_v[LAT-1] | inj;
    vector = inj ? inj_d : {16{pipe_t[LAT-1]}};
    if (pipe_v[LAT-1]) results++;
    inj = 1'b0;
    for (int i = LAT-1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_t[i] = pipe_t[i-1];
    end
    pipe_v[0] = fire_s;
    pipe_t[0] = tag;
    if (fire_s) begin
      exp_q.push_back({16{tag}});
      tag++;
      fires++;
    end
  endtask

  task automatic do_reset();
    issue_req = 1'b0;
    m_ready = 1'b0;
    inj = 1'b0;
    vector_output_valid = 1'b0;
    vector = '0;
    rst_n = 1'b0;
    #1;
    chk_i("rst_err", int'(err_unexpected), 0);
    chk_i("rst_mvalid", int'(m_valid), 0);
    chk_i("rst_grant", int'(issue_grant), 0);
    chk("rst_mdata", m_data, '0);
    chk_i("rst_occ", int'(occupancy), 0);
    for (int i = 0; i < LAT; i++) begin
      pipe_v[i] = 1'b0;
      pipe_t[i] = '0;
    end
    exp_q.delete();
    fires = 0;
    results = 0;
    pops = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk_i("rel_grant", int'(issue_grant), 1);
  endtask

  initial begin
    logic [DATA_W-1:0] d0;
    int                c;
    tbl[0] = '{32'hA5A5A5A5, {16{32'hA5A5A5A5}}};
    tbl[1] = '{32'h00000000, {DATA_W{1'b0}}};
    tbl[2] = '{32'hFFFFFFFF, {DATA_W{1'b1}}};
    tbl[3] = '{32'h12345678, {16{32'h12345678}}};
    tag = '0;
    rst_n = 1'b0;
    do_reset();

    // single passes: 1-cycle latency into an empty FIFO
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tag = tbl[k].tag;
      issue_req = 1'b1;
      step();
      issue_req = 1'b0;
      c = 0;
      while (!vector_output_valid && c < 40) begin
        step();
        c++;
      end
      chk_i("sp_arrive", int'(vector_output_valid), 1);
      chk_i("sp_mvalid_T", int'(m_valid), 0);
      step();
      chk_i("sp_mvalid_T1", int'(m_valid), 1);
      chk("sp_mdata", m_data, tbl[k].exp_data);
      step();
      chk_i("sp_occ", int'(occupancy), 0);
      chk_i("sp_err", int'(err_unexpected), 0);
    end

    // credit exhaustion
    do_reset();
    m_ready = 1'b0;
    issue_req = 1'b1;
    repeat (26) step();
    issue_req = 1'b0;
    chk_i("ex_grants", fires, 16);
    chk_i("ex_grant_low", int'(issue_grant), 0);
    repeat (LAT + 2) step();
    chk_i("ex_results", results, 16);
    chk_i("ex_occ", int'(occupancy), 16);
    chk_i("ex_grant_full", int'(issue_grant), 0);
    d0 = m_data;
    step();
    chk("ex_hold", m_data, d0);
`ifdef VADD_COLLECT_PERF_EN
    chk_i("perf_results", int'(perf_results), 16);
    chk_i("perf_stall_issue", int'(perf_stall_issue), 10);
`endif
    m_ready = 1'b1;
    #1;
    chk_i("ex_pop_grant", int'(issue_grant), 1);
    step();
    m_ready = 1'b0;
    chk_i("ex_occ_pop", int'(occupancy), 15);
    m_ready = 1'b1;
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      step();
      c++;
    end
    chk_i("ex_drained", exp_q.size(), 0);
    chk_i("ex_occ_end", int'(occupancy), 0);

    // ordering and pointer wrap with random backpressure
    do_reset();
    tag = '0;
    c = 0;
    while (!(fires == 40 && exp_q.size() == 0) && c < 3000) begin
      issue_req = (fires < 40);
      m_ready = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    issue_req = 1'b0;
    m_ready = 1'b0;
    chk_i("ord_fires", fires, 40);
    chk_i("ord_pops", pops, 40);
    chk_i("ord_occ", int'(occupancy), 0);

    // simultaneous issue, result and pop
    do_reset();
    tag = 32'h100;
    c = 0;
    while (fires < 12 && c < 50) begin
      issue_req = 1'b1;
      step();
      c++;
    end
    issue_req = 1'b0;
    c = 0;
    while (results < 9 && c < 50) begin
      step();
      c++;
    end
    chk_i("sim_pre_occ", int'(occupancy), 12);
    issue_req = 1'b1;
    m_ready = 1'b1;
    step();
    issue_req = 1'b0;
    m_ready = 1'b0;
    chk_i("sim_fires", fires, 13);
    chk_i("sim_occ", int'(occupancy), 12);
    repeat (LAT + 4) step();
    chk_i("sim_occ_all", int'(occupancy), 12);
    m_ready = 1'b1;
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      step();
      c++;
    end
    chk_i("sim_drained", exp_q.size(), 0);

    // unexpected result
    do_reset();
    m_ready = 1'b1;
    inj = 1'b1;
    inj_d = 512'h1234;
    exp_q.push_back(512'h1234);
    step();
    chk_i("ux_err_pre", int'(err_unexpected), 0);
    step();
    chk_i("ux_err", int'(err_unexpected), 1);
    chk_i("ux_occ", int'(occupancy), 1);
    chk("ux_data", m_data, 512'h1234);
    step();
    chk_i("ux_occ_after", int'(occupancy), 0);
    repeat (3) step();
    chk_i("ux_err_sticky", int'(err_unexpected), 1);
    m_ready = 1'b0;
    inj = 1'b1;
    inj_d = 512'h5678;
    exp_q.push_back(512'h5678);
    step();
    step();
    chk_i("ux_mvalid", int'(m_valid), 1);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
